// File: rtl/mc_controller.sv
// Multi-cycle MIPS main controller: sequences the shared ALU and the unified memory through FETCH/DECODE/EXEC/MEM/WB.
// Latency: 2 cycles for NOP/J/JAL/JR, 3 for BEQ, 4 for SW and ALU ops, 5 for LW, when mem_ready returns in the same cycle.
// Backpressure: FETCH and MEM hold until mem_ready; after MEM_WAIT_MAX waiting cycles mem_err is set and the FSM parks in HALT.
//
// Ports: clk/reset_n (async active-low); op/funct from the IR; zero flag from the ALU; mem_ready from memory.
//        Outputs: PC/IR/RF enables, memory requests, datapath mux selects, ALU op, sticky mem_err, debug state.
// Optional feature: define ILLEGAL_TRAP_EN to make unrecognised encodings trap to HALT and raise the sticky illegal_op output.
module mc_controller #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int WAIT_CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       ir_en,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] pc_src,
    output logic       mem_err,
    output logic [2:0] state
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_op
`endif
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI,
        C_LW, C_SW, C_BEQ, C_J, C_JAL, C_ILL
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b011;

    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_WAIT_MAX - 1);

    function automatic cls_t decode(input logic [5:0] op_i, input logic [5:0] funct_i);
        cls_t c;
        c = C_ILL;
        case (op_i)
            6'h00: begin
                case (funct_i)
                    6'h00:   c = C_NOP;
                    6'h21:   c = C_ADDU;
                    6'h23:   c = C_SUBU;
                    6'h08:   c = C_JR;
                    default: c = C_ILL;
                endcase
            end
            6'h0d:   c = C_ORI;
            6'h0f:   c = C_LUI;
            6'h23:   c = C_LW;
            6'h2b:   c = C_SW;
            6'h04:   c = C_BEQ;
            6'h02:   c = C_J;
            6'h03:   c = C_JAL;
            default: c = C_ILL;
        endcase
        return c;
    endfunction

    state_t                state_q, state_d;
    cls_t                  class_q, class_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic                  mem_err_q, mem_err_d;
    cls_t                  dec_cls;
`ifdef ILLEGAL_TRAP_EN
    logic                  illegal_q, illegal_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            class_q    <= C_NOP;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            class_q    <= class_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
`ifdef ILLEGAL_TRAP_EN
            illegal_q  <= illegal_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        wait_cnt_d  = '0;
        mem_err_d   = mem_err_q;
`ifdef ILLEGAL_TRAP_EN
        illegal_d   = illegal_q;
`endif
        pc_en       = 1'b0;
        ir_en       = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'd0;
        alu_control = ALU_ADD;
        pc_src      = 2'd0;
        // The IR only became valid this cycle, so DECODE acts on the class
        // being latched rather than on the stale class register.
        dec_cls     = decode(op, funct);

        // Shared wait accounting for FETCH and MEM: the counter stays zero in
        // every other state, so entering FETCH/MEM always starts from zero.
        if ((state_q == S_FETCH || state_q == S_MEM) && !mem_ready) begin
            if (wait_cnt_q == WAIT_LAST) begin
                mem_err_d = 1'b1;
                state_d   = S_HALT;
            end else begin
                wait_cnt_d = wait_cnt_q + WAIT_CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: state_d = S_FETCH;

            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    ir_en   = 1'b1;
                    pc_en   = 1'b1;
                    state_d = S_DECODE;
                end
            end

            S_DECODE: begin
                alu_src_b = 2'd3;
                class_d   = dec_cls;
                state_d   = S_FETCH;
                case (dec_cls)
                    C_NOP: ;
                    C_J: begin
                        pc_en  = 1'b1;
                        pc_src = 2'd2;
                    end
                    C_JR: begin
                        pc_en  = 1'b1;
                        pc_src = 2'd3;
                    end
                    C_JAL: begin
                        pc_en      = 1'b1;
                        pc_src     = 2'd2;
                        reg_write  = 1'b1;
                        reg_dst    = 2'd2;
                        mem_to_reg = 2'd2;
                    end
                    C_ILL: begin
`ifdef ILLEGAL_TRAP_EN
                        illegal_d = 1'b1;
                        state_d   = S_HALT;
`else
                        class_d   = C_NOP;
`endif
                    end
                    default: state_d = S_EXEC;
                endcase
            end

            S_EXEC: begin
                alu_src_a = 1'b1;
                state_d   = S_WB;
                case (class_q)
                    C_ADDU: alu_control = ALU_ADD;
                    C_SUBU: alu_control = ALU_SUB;
                    C_ORI: begin
                        alu_src_b   = 2'd2;
                        alu_control = ALU_OR;
                    end
                    C_LUI: begin
                        alu_src_b   = 2'd2;
                        alu_control = ALU_LUI;
                    end
                    // Address offset enters on the imm port; the datapath
                    // sign-extends it for memory ops.
                    C_LW, C_SW: begin
                        alu_src_b = 2'd2;
                        state_d   = S_MEM;
                    end
                    C_BEQ: begin
                        alu_control = ALU_SUB;
                        pc_en       = zero;
                        pc_src      = 2'd1;
                        state_d     = S_FETCH;
                    end
                    default: state_d = S_FETCH;
                endcase
            end

            S_MEM: begin
                i_or_d    = 1'b1;
                mem_read  = (class_q == C_LW);
                mem_write = (class_q == C_SW);
                if (mem_ready) begin
                    state_d = (class_q == C_LW) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                case (class_q)
                    C_ADDU, C_SUBU: reg_dst = 2'd1;
                    C_LW:           mem_to_reg = 2'd1;
                    default:        reg_dst = 2'd0;
                endcase
            end

            S_HALT: ;

            default: state_d = S_IDLE;
        endcase
    end

    assign mem_err = mem_err_q;
    assign state   = state_q;
`ifdef ILLEGAL_TRAP_EN
    assign illegal_op = illegal_q;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: a per-cycle vector table covering every instruction class,
// plus hand sequences for memory stalls, timeout boundary, reset during MEM and illegal opcodes.
// Outputs are sampled 1 time unit after the falling edge, well away from the rising edge.
module tb_mc_controller;

    logic       clk;
    logic       reset_n;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_en, ir_en, i_or_d, mem_read, mem_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic       alu_src_a;
    logic [2:0] alu_control;
    logic       mem_err;
    logic [2:0] state;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_op;
`endif

    int checks = 0;
    int errors = 0;

    mc_controller #(.MEM_WAIT_MAX(15), .WAIT_CNT_W(4)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op          (op),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .ir_en       (ir_en),
        .i_or_d      (i_or_d),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .reg_write   (reg_write),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_control (alu_control),
        .pc_src      (pc_src),
        .mem_err     (mem_err),
        .state       (state)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [2:0] st;
        logic       pc_en, ir_en, i_or_d, mem_read, mem_write, reg_write;
        logic [1:0] reg_dst, mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] pc_src;
    } out_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        logic       rdy;
        out_t       exp;
    } vec_t;

    vec_t tbl[$];

    // Argument order: state, pc_en, ir_en, i_or_d, mem_read, mem_write, reg_write,
    // reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_control, pc_src
    function automatic out_t o(input int st, input int pe, input int ie, input int iod,
                               input int mr, input int mw, input int rw, input int rd,
                               input int m2r, input int a, input int b, input int alu,
                               input int ps);
        out_t r;
        r.st          = 3'(st);
        r.pc_en       = 1'(pe);
        r.ir_en       = 1'(ie);
        r.i_or_d      = 1'(iod);
        r.mem_read    = 1'(mr);
        r.mem_write   = 1'(mw);
        r.reg_write   = 1'(rw);
        r.reg_dst     = 2'(rd);
        r.mem_to_reg  = 2'(m2r);
        r.alu_src_a   = 1'(a);
        r.alu_src_b   = 2'(b);
        r.alu_control = 3'(alu);
        r.pc_src      = 2'(ps);
        return r;
    endfunction

    function automatic out_t cur();
        out_t r;
        r.st          = state;
        r.pc_en       = pc_en;
        r.ir_en       = ir_en;
        r.i_or_d      = i_or_d;
        r.mem_read    = mem_read;
        r.mem_write   = mem_write;
        r.reg_write   = reg_write;
        r.reg_dst     = reg_dst;
        r.mem_to_reg  = mem_to_reg;
        r.alu_src_a   = alu_src_a;
        r.alu_src_b   = alu_src_b;
        r.alu_control = alu_control;
        r.pc_src      = pc_src;
        return r;
    endfunction

    task automatic add(input string nm, input int op_i, input int funct_i, input int z,
                       input int r, input out_t e);
        vec_t v;
        v.name  = nm;
        v.op    = 6'(op_i);
        v.funct = 6'(funct_i);
        v.zero  = 1'(z);
        v.rdy   = 1'(r);
        v.exp   = e;
        tbl.push_back(v);
    endtask

    task automatic chk_out(input string nm, input out_t e);
        out_t a;
        a = cur();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h (state %0d) expected %h (state %0d)", nm, a, a.st, e, e.st);
        end
    endtask

    task automatic chk_bit(input string nm, input logic a, input logic e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, a, e);
        end
    endtask

    task automatic cyc(input int op_i, input int funct_i, input int z, input int r);
        @(negedge clk);
        op        = 6'(op_i);
        funct     = 6'(funct_i);
        zero      = 1'(z);
        mem_ready = 1'(r);
        #1;
    endtask

    // Asserts reset asynchronously, checks the reset state, then releases on a
    // falling edge and checks IDLE before the next rising edge.
    task automatic do_reset(input string nm);
        reset_n = 1'b0;
        #1;
        chk_out({nm, "_rst_out"}, o(0,0,0,0,0,0,0,0,0,0,0,0,0));
        chk_bit({nm, "_rst_err"}, mem_err, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        chk_bit({nm, "_rst_ill"}, illegal_op, 1'b0);
`endif
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk_out({nm, "_idle"}, o(0,0,0,0,0,0,0,0,0,0,0,0,0));
    endtask

    out_t F_RDY, F_WAIT, DEC, HALT_O;

    initial begin
        F_RDY  = o(1,1,1,0,1,0,0,0,0,0,1,0,0);
        F_WAIT = o(1,0,0,0,1,0,0,0,0,0,1,0,0);
        DEC    = o(2,0,0,0,0,0,0,0,0,0,3,0,0);
        HALT_O = o(6,0,0,0,0,0,0,0,0,0,0,0,0);

        // ADDU: states 1,2,3,5; zero asserted in EXEC must not matter
        add("addu_f",  'h00,'h21,0,1, F_RDY);
        add("addu_d",  'h00,'h21,0,1, DEC);
        add("addu_x",  'h00,'h21,1,1, o(3,0,0,0,0,0,0,0,0,1,0,0,0));
        add("addu_wb", 'h00,'h21,0,1, o(5,0,0,0,0,0,1,1,0,0,0,0,0));
        add("subu_f",  'h00,'h23,0,1, F_RDY);
        add("subu_d",  'h00,'h23,0,1, DEC);
        add("subu_x",  'h00,'h23,0,1, o(3,0,0,0,0,0,0,0,0,1,0,1,0));
        add("subu_wb", 'h00,'h23,0,1, o(5,0,0,0,0,0,1,1,0,0,0,0,0));
        add("ori_f",   'h0d,'h00,0,1, F_RDY);
        add("ori_d",   'h0d,'h00,0,1, DEC);
        add("ori_x",   'h0d,'h00,0,1, o(3,0,0,0,0,0,0,0,0,1,2,2,0));
        add("ori_wb",  'h0d,'h00,0,1, o(5,0,0,0,0,0,1,0,0,0,0,0,0));
        add("lui_f",   'h0f,'h00,0,1, F_RDY);
        add("lui_d",   'h0f,'h00,0,1, DEC);
        add("lui_x",   'h0f,'h00,0,1, o(3,0,0,0,0,0,0,0,0,1,2,3,0));
        add("lui_wb",  'h0f,'h00,0,1, o(5,0,0,0,0,0,1,0,0,0,0,0,0));
        add("lw_f",    'h23,'h00,0,1, F_RDY);
        add("lw_d",    'h23,'h00,0,1, DEC);
        add("lw_x",    'h23,'h00,0,1, o(3,0,0,0,0,0,0,0,0,1,2,0,0));
        add("lw_m",    'h23,'h00,0,1, o(4,0,0,1,1,0,0,0,0,0,0,0,0));
        add("lw_wb",   'h23,'h00,0,1, o(5,0,0,0,0,0,1,0,1,0,0,0,0));
        add("sw_f",    'h2b,'h00,0,1, F_RDY);
        add("sw_d",    'h2b,'h00,0,1, DEC);
        add("sw_x",    'h2b,'h00,0,1, o(3,0,0,0,0,0,0,0,0,1,2,0,0));
        add("sw_m",    'h2b,'h00,0,1, o(4,0,0,1,0,1,0,0,0,0,0,0,0));
        add("beq1_f",  'h04,'h00,0,1, F_RDY);
        add("beq1_d",  'h04,'h00,0,1, DEC);
        add("beq1_x",  'h04,'h00,1,1, o(3,1,0,0,0,0,0,0,0,1,0,1,1));
        add("beq0_f",  'h04,'h00,0,1, F_RDY);
        add("beq0_d",  'h04,'h00,0,1, DEC);
        add("beq0_x",  'h04,'h00,0,1, o(3,0,0,0,0,0,0,0,0,1,0,1,1));
        add("j_f",     'h02,'h00,0,1, F_RDY);
        add("j_d",     'h02,'h00,0,1, o(2,1,0,0,0,0,0,0,0,0,3,0,2));
        add("jal_f",   'h03,'h00,0,1, F_RDY);
        add("jal_d",   'h03,'h00,0,1, o(2,1,0,0,0,0,1,2,2,0,3,0,2));
        add("jr_f",    'h00,'h08,0,1, F_RDY);
        add("jr_d",    'h00,'h08,0,1, o(2,1,0,0,0,0,0,0,0,0,3,0,3));
`ifndef ILLEGAL_TRAP_EN
        add("unk_f",   'h00,'h3f,0,1, F_RDY);
        add("unk_d",   'h00,'h3f,0,1, DEC);
`endif
        add("nop_f",   'h00,'h00,0,1, F_RDY);
        add("nop_d",   'h00,'h00,0,1, DEC);

        reset_n   = 1'b0;
        op        = '0;
        funct     = '0;
        zero      = 1'b0;
        mem_ready = 1'b0;

        do_reset("init");

        foreach (tbl[i]) begin
            cyc(tbl[i].op, tbl[i].funct, tbl[i].zero, tbl[i].rdy);
            chk_out(tbl[i].name, tbl[i].exp);
        end
        chk_bit("table_no_err", mem_err, 1'b0);

        // LW with memory stalled three cycles: MEM held four cycles in total
        cyc('h23,0,0,1); chk_out("lws_f", F_RDY);
        cyc('h23,0,0,1); chk_out("lws_d", DEC);
        cyc('h23,0,0,1); chk_out("lws_x", o(3,0,0,0,0,0,0,0,0,1,2,0,0));
        for (int k = 0; k < 3; k++) begin
            cyc('h23,0,0,0);
            chk_out($sformatf("lws_mwait%0d", k), o(4,0,0,1,1,0,0,0,0,0,0,0,0));
        end
        cyc('h23,0,0,1); chk_out("lws_mdone", o(4,0,0,1,1,0,0,0,0,0,0,0,0));
        cyc('h23,0,0,1); chk_out("lws_wb", o(5,0,0,0,0,0,1,0,1,0,0,0,0));

        // SW pending in MEM when reset hits: must drop straight to IDLE
        cyc('h2b,0,0,1); chk_out("swr_f", F_RDY);
        cyc('h2b,0,0,1); chk_out("swr_d", DEC);
        cyc('h2b,0,0,1); chk_out("swr_x", o(3,0,0,0,0,0,0,0,0,1,2,0,0));
        cyc('h2b,0,0,0); chk_out("swr_mwait", o(4,0,0,1,0,1,0,0,0,0,0,0,0));
        do_reset("swr");

        // mem_ready on the 15th waiting cycle still wins over the timeout
        for (int k = 0; k < 14; k++) begin
            cyc(0,0,0,0);
            chk_out($sformatf("bnd_wait%0d", k), F_WAIT);
        end
        cyc(0,0,0,1); chk_out("bnd_last_rdy", F_RDY);
        chk_bit("bnd_no_err", mem_err, 1'b0);
        cyc(0,0,0,1); chk_out("bnd_d", DEC);

        // 15 waiting cycles in FETCH with no response: timeout to HALT
        for (int k = 0; k < 15; k++) begin
            cyc(0,0,0,0);
            chk_out($sformatf("to_wait%0d", k), F_WAIT);
        end
        chk_bit("to_err_before", mem_err, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cyc('h23,0,1,k % 2);
            chk_out($sformatf("to_halt%0d", k), HALT_O);
            chk_bit($sformatf("to_err%0d", k), mem_err, 1'b1);
        end
        do_reset("to");

        // Unrecognised opcode 3f
        cyc('h3f,0,0,1); chk_out("ill_f", F_RDY);
        cyc('h3f,0,0,1); chk_out("ill_d", DEC);
        cyc('h3f,0,0,0);
`ifdef ILLEGAL_TRAP_EN
        chk_out("ill_halt", HALT_O);
        chk_bit("ill_flag", illegal_op, 1'b1);
        cyc(0,0,0,1);
        chk_out("ill_stay", HALT_O);
        do_reset("ill");
`else
        chk_out("ill_back_fetch", F_WAIT);
        chk_bit("ill_no_err", mem_err, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
